// File: rtl/icb_ext_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// icb_types : shared ICB-extended bus types for the accelerator loaders and
// the scratchpad SRAM slave.
//   icb_ext_cmd_m_t  master->slave command   (valid, addr, read, len)
//   icb_ext_cmd_s_t  slave->master command   (cmd_ready)
//   icb_ext_wr_m_t   master->slave write     (w_valid, wdata, wmask)
//   icb_ext_wr_s_t   slave->master write     (w_ready)
//   icb_ext_rsp_s_t  slave->master response  (rsp_valid, rdata, err)
//   icb_ext_rsp_m_t  master->slave response  (rsp_ready)
// A burst carries len+1 beats; len is ICB_LEN_W bits wide.
// ---------------------------------------------------------------------------
package icb_types;

   localparam int ICB_ADDR_W = 32;
   localparam int ICB_DATA_W = 32;
   localparam int ICB_MASK_W = ICB_DATA_W / 8;
   localparam int ICB_LEN_W  = 3;

   // Size field encoding, log2 of the beat size in bytes (word = 4 bytes).
   localparam logic [1:0] ICB_SIZE_WORD = 2'd2;

   typedef struct packed {
      logic                  valid;
      logic [ICB_ADDR_W-1:0] addr;
      logic                  read;
      logic [ICB_LEN_W-1:0]  len;
   } icb_ext_cmd_m_t;

   typedef struct packed {
      logic cmd_ready;
   } icb_ext_cmd_s_t;

   typedef struct packed {
      logic                  w_valid;
      logic [ICB_DATA_W-1:0] wdata;
      logic [ICB_MASK_W-1:0] wmask;
   } icb_ext_wr_m_t;

   typedef struct packed {
      logic w_ready;
   } icb_ext_wr_s_t;

   typedef struct packed {
      logic                  rsp_valid;
      logic [ICB_DATA_W-1:0] rdata;
      logic                  err;
   } icb_ext_rsp_s_t;

   typedef struct packed {
      logic rsp_ready;
   } icb_ext_rsp_m_t;

   typedef enum logic [1:0] {
      SLV_IDLE     = 2'd0,
      SLV_RD_BURST = 2'd1,
      SLV_WR_BURST = 2'd2,
      SLV_WR_RSP   = 2'd3
   } slv_state_t;

   // Bytes carried by one beat of the given data width.
   function automatic int beat_bytes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/icb_ext_sram_slave_sram.sv
// ---------------------------------------------------------------------------
// sram_1rw_bm : single-port synchronous RAM with per-byte write mask.
//   clk    clock
//   en     access enable (read when we=0, write when we=1)
//   we     write enable
//   addr   word address
//   wmask  per-byte write enable, bit b covers wdata[8b+7:8b]
//   wdata  write data
//   rdata  read data, valid the cycle after a read access; holds otherwise
// Contents are not reset.
// ---------------------------------------------------------------------------
module sram_1rw_bm #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH/8-1:0]       wmask,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   localparam int MW = WIDTH / 8;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < MW; b++) begin
               if (wmask[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/icb_ext_sram_slave.sv
// ---------------------------------------------------------------------------
// icb_ext_sram_slave : ICB-extended burst slave over a word-addressed SRAM
// window starting at byte address BASE_ADDR.
//   clk, rst_n   clock, asynchronous active-low reset
//   icb_cmd_m/s  command channel; one outstanding burst of len+1 beats
//   icb_wr_m/s   write beats with byte masks (accepted only in a write burst)
//   icb_rsp_s/m  response channel; one response per read beat, one per write
//                burst; err flags out-of-range / misaligned beats
// Read beats flow through a 2-deep response FIFO with a bypass from the SRAM
// output, so the first beat shows two cycles after command acceptance.
// DATA_WIDTH / ADDR_WIDTH must match the package bus widths.
// ---------------------------------------------------------------------------
module icb_ext_sram_slave
   import icb_types::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DEPTH_WORDS = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  icb_ext_cmd_m_t icb_cmd_m,
   output icb_ext_cmd_s_t icb_cmd_s,
   input  icb_ext_wr_m_t  icb_wr_m,
   output icb_ext_wr_s_t  icb_wr_s,
   output icb_ext_rsp_s_t icb_rsp_s,
   input  icb_ext_rsp_m_t icb_rsp_m
);

   localparam int BYTES = beat_bytes(DATA_WIDTH);
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH_WORDS);
   localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(BYTES);

   slv_state_t              state;
   logic [ADDR_WIDTH-1:0]   beat_addr;
   logic [ICB_LEN_W:0]      beats_left;
   logic                    err_acc;
   logic [1:0]              cnt;
   logic                    rd_vld_p1;
   logic                    rd_err_p1;
   logic [DATA_WIDTH-1:0]   q_data0, q_data1;
   logic                    q_err0, q_err1;
   logic [DATA_WIDTH-1:0]   sram_q;

   logic [ADDR_WIDTH-1:0]   beat_off;
   logic                    beat_below;
   logic [ADDR_WIDTH-1:0]   beat_idx;
   logic                    beat_err;
   logic                    cmd_fire, rd_issue, wr_fire, rsp_fire;
   logic                    fifo_pop, byp_pop, push;
   logic [1:0]              cnt_nx;
   logic [DATA_WIDTH-1:0]   land_data;
   logic                    rsp_valid, rsp_err;
   logic [DATA_WIDTH-1:0]   rsp_data;

   // Range check of the current beat; the borrow of the subtraction flags
   // addresses below the window.
   assign {beat_below, beat_off} = {1'b0, beat_addr} - {1'b0, BASE_ADDR};
   assign beat_idx = beat_off >> OFF_W;
   assign beat_err = beat_below | ((beat_addr & OFF_MASK) != '0) | (beat_idx >= DEPTH_A);

   assign cmd_fire = icb_cmd_m.valid && (state == SLV_IDLE);
   assign wr_fire  = icb_wr_m.w_valid && (state == SLV_WR_BURST);
   // Issue only while buffered plus in-flight beats leave room in the FIFO.
   assign rd_issue = (state == SLV_RD_BURST) && (beats_left != '0) &&
                     ((3'(cnt) + 3'(rd_vld_p1)) < 3'd2);

   assign rsp_fire = rsp_valid && icb_rsp_m.rsp_ready;
   assign fifo_pop = rsp_fire && (cnt != 2'd0);
   assign byp_pop  = rsp_fire && (cnt == 2'd0) && rd_vld_p1;
   assign push     = rd_vld_p1 && !byp_pop;
   assign cnt_nx   = cnt + 2'(push) - 2'(fifo_pop);

   assign land_data = rd_err_p1 ? '0 : sram_q;

   always_comb begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
      if (state == SLV_WR_RSP) begin
         rsp_valid = 1'b1;
         rsp_err   = err_acc;
      end else if (cnt != 2'd0) begin
         rsp_valid = 1'b1;
         rsp_data  = q_data0;
         rsp_err   = q_err0;
      end else if (rd_vld_p1) begin
         rsp_valid = 1'b1;
         rsp_data  = land_data;
         rsp_err   = rd_err_p1;
      end
   end

   assign icb_cmd_s.cmd_ready = (state == SLV_IDLE);
   assign icb_wr_s.w_ready    = (state == SLV_WR_BURST);
   assign icb_rsp_s.rsp_valid = rsp_valid;
   assign icb_rsp_s.rdata     = rsp_data;
   assign icb_rsp_s.err       = rsp_err;

   // Out-of-range beats never touch the array.
   sram_1rw_bm #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH_WORDS)
   ) u_sram (
      .clk   (clk),
      .en    ((rd_issue | wr_fire) & ~beat_err),
      .we    (wr_fire),
      .addr  (beat_idx[IDX_W-1:0]),
      .wmask (icb_wr_m.wmask),
      .wdata (icb_wr_m.wdata),
      .rdata (sram_q)
   );

   // Stage p0 -> p1: SRAM read in flight, landing next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SLV_IDLE;
         beat_addr  <= '0;
         beats_left <= '0;
         err_acc    <= 1'b0;
         cnt        <= 2'd0;
         rd_vld_p1  <= 1'b0;
         rd_err_p1  <= 1'b0;
      end else begin
         rd_vld_p1 <= rd_issue;
         rd_err_p1 <= rd_issue & beat_err;
         cnt       <= cnt_nx;
         case (state)
            SLV_IDLE: begin
               if (cmd_fire) begin
                  beat_addr  <= icb_cmd_m.addr;
                  beats_left <= {1'b0, icb_cmd_m.len} + 1'b1;
                  err_acc    <= 1'b0;
                  state      <= icb_cmd_m.read ? SLV_RD_BURST : SLV_WR_BURST;
               end
            end
            SLV_RD_BURST: begin
               if (rd_issue) begin
                  beat_addr  <= beat_addr + STEP;
                  beats_left <= beats_left - 1'b1;
               end
               // All beats issued; leave once nothing is buffered or landing.
               if ((beats_left == '0) && (cnt_nx == 2'd0)) state <= SLV_IDLE;
            end
            SLV_WR_BURST: begin
               if (wr_fire) begin
                  beat_addr  <= beat_addr + STEP;
                  beats_left <= beats_left - 1'b1;
                  err_acc    <= err_acc | beat_err;
                  if (beats_left == (ICB_LEN_W+1)'(1)) state <= SLV_WR_RSP;
               end
            end
            SLV_WR_RSP: begin
               if (icb_rsp_m.rsp_ready) state <= SLV_IDLE;
            end
            default: state <= SLV_IDLE;
         endcase
      end
   end

   // Stage p1 -> FIFO: entry 0 is the head; a push lands in the first free
   // slot after any simultaneous pop.
   always_ff @(posedge clk) begin
      if (fifo_pop) begin
         q_data0 <= q_data1;
         q_err0  <= q_err1;
      end
      if (push) begin
         if ((cnt == 2'd0) || ((cnt == 2'd1) && fifo_pop)) begin
            q_data0 <= land_data;
            q_err0  <= rd_err_p1;
         end else begin
            q_data1 <= land_data;
            q_err1  <= rd_err_p1;
         end
      end
   end

endmodule

// File: tb/tb_icb_ext_sram_slave.sv
module tb_icb_ext_sram_slave;
   import icb_types::*;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   icb_ext_cmd_m_t cmd_m;
   icb_ext_cmd_s_t cmd_s;
   icb_ext_wr_m_t  wr_m;
   icb_ext_wr_s_t  wr_s;
   icb_ext_rsp_s_t rsp_s;
   icb_ext_rsp_m_t rsp_m;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] wd [8];
   logic [3:0]  wm [8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   icb_ext_sram_slave #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .icb_cmd_m(cmd_m),
      .icb_cmd_s(cmd_s),
      .icb_wr_m (wr_m),
      .icb_wr_s (wr_s),
      .icb_rsp_s(rsp_s),
      .icb_rsp_m(rsp_m)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Reference rules: per-beat byte address decides range, index and data.
   function automatic logic beat_bad(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a < BASE) || ((a & 32'h3) != 32'h0) || ((off >> 2) >= 32'(DEPTH));
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      if (beat_bad(a)) return 32'h0;
      return model[(a - BASE) >> 2];
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int idx;
      if (!beat_bad(a)) begin
         idx = int'((a - BASE) >> 2);
         for (int b = 0; b < 4; b++) if (m[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   task automatic slot();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_s.cmd_ready), 32'd1);
      chk({tag, "_w_ready"},   32'(wr_s.w_ready),    32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_s.rsp_valid), 32'd0);
      chk({tag, "_rdata"},     rsp_s.rdata,          32'd0);
      chk({tag, "_err"},       32'(rsp_s.err),       32'd0);
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic rd, input logic [2:0] len,
                           output int t_acc);
      int n;
      n = 0;
      cmd_m.valid = 1'b1;
      cmd_m.addr  = a;
      cmd_m.read  = rd;
      cmd_m.len   = len;
      @(negedge clk);
      while (!cmd_s.cmd_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      t_acc = cyc;
      chk("cmd_accept", 32'(cmd_s.cmd_ready), 32'd1);
      slot();
      cmd_m.valid = 1'b0;
   endtask

   // mode 0: rsp_ready=1, 1: pattern 1,0,0 repeating, 2: random.
   task automatic do_read(input logic [31:0] a, input logic [2:0] len, input int mode,
                          input logic chk_lat);
      int t, k, n, last;
      logic first, stalled, prev_e;
      logic [31:0] prev_d, ba;
      send_cmd(a, 1'b1, len, t);
      k = 0; n = 0; last = 0; first = 1'b1; stalled = 1'b0; prev_d = '0; prev_e = 1'b0;
      while (k <= int'(len) && n < 200) begin
         case (mode)
            0:       rsp_m.rsp_ready = 1'b1;
            1:       rsp_m.rsp_ready = ((n % 3) == 0);
            default: rsp_m.rsp_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         chk("rd_busy_cmd_ready", 32'(cmd_s.cmd_ready), 32'd0);
         if (stalled) begin
            chk("rd_hold_valid", 32'(rsp_s.rsp_valid), 32'd1);
            chk("rd_hold_data",  rsp_s.rdata,          prev_d);
            chk("rd_hold_err",   32'(rsp_s.err),       32'(prev_e));
         end
         if (rsp_s.rsp_valid) begin
            if (first && chk_lat) chk("rd_first_latency", 32'(cyc - t), 32'd2);
            first = 1'b0;
            if (rsp_m.rsp_ready) begin
               ba = a + 32'(4 * k);
               chk("rd_data", rsp_s.rdata, exp_rd(ba));
               chk("rd_err", 32'(rsp_s.err), 32'(beat_bad(ba)));
               k++;
               last = cyc;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               prev_d = rsp_s.rdata;
               prev_e = rsp_s.err;
            end
         end
         slot();
         n++;
      end
      chk("rd_beats", 32'(k), 32'(int'(len) + 1));
      if (mode == 0) chk("rd_last_latency", 32'(last - t), 32'(int'(len) + 2));
      rsp_m.rsp_ready = 1'b1;
      @(negedge clk);
      chk("rd_done_cmd_ready", 32'(cmd_s.cmd_ready), 32'd1);
      chk("rd_done_rsp_valid", 32'(rsp_s.rsp_valid), 32'd0);
      slot();
      rsp_m.rsp_ready = 1'b0;
   endtask

   // Beats come from wd/wm; mode 1 inserts random w_valid and rsp_ready gaps.
   task automatic do_write(input logic [31:0] a, input logic [2:0] len, input int mode);
      int t, k, n;
      logic exp_err, done;
      exp_err = 1'b0;
      for (int i = 0; i <= int'(len); i++) exp_err |= beat_bad(a + 32'(4 * i));
      send_cmd(a, 1'b0, len, t);
      k = 0; n = 0;
      while (k <= int'(len) && n < 200) begin
         wr_m.w_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         wr_m.wdata   = wd[k];
         wr_m.wmask   = wm[k];
         @(negedge clk);
         chk("wr_w_ready", 32'(wr_s.w_ready), 32'd1);
         chk("wr_no_early_rsp", 32'(rsp_s.rsp_valid), 32'd0);
         if (wr_m.w_valid) begin
            model_write(a + 32'(4 * k), wd[k], wm[k]);
            k++;
         end
         slot();
         n++;
      end
      wr_m.w_valid = 1'b0;
      done = 1'b0; n = 0;
      while (!done && n < 50) begin
         rsp_m.rsp_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("wr_rsp_valid", 32'(rsp_s.rsp_valid), 32'd1);
         chk("wr_rsp_rdata", rsp_s.rdata, 32'd0);
         chk("wr_rsp_err", 32'(rsp_s.err), 32'(exp_err));
         chk("wr_rsp_w_ready", 32'(wr_s.w_ready), 32'd0);
         if (rsp_m.rsp_ready) done = 1'b1;
         slot();
         n++;
      end
      chk("wr_rsp_taken", 32'(done), 32'd1);
      rsp_m.rsp_ready = 1'b0;
      @(negedge clk);
      chk("wr_done_cmd_ready", 32'(cmd_s.cmd_ready), 32'd1);
      chk("wr_done_rsp_valid", 32'(rsp_s.rsp_valid), 32'd0);
      slot();
   endtask

   task automatic fill_random(input logic full_mask);
      for (int i = 0; i < 8; i++) begin
         wd[i] = $urandom;
         wm[i] = full_mask ? 4'hF : 4'($urandom_range(0, 15));
      end
   endtask

   initial begin
      int t, r;
      logic [31:0] a;
      logic [2:0] len;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      cmd_m = '0;
      wr_m  = '0;
      rsp_m = '0;

      // Reset values, during and after reset.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("in_reset");
      slot();
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("after_reset");
      slot();

      // Preload the regions used below with known contents.
      for (int blk = 0; blk < 3; blk++) begin
         fill_random(1'b1);
         do_write(BASE + 32'(32 * blk), 3'd7, 0);
      end
      fill_random(1'b1);
      do_write(BASE + 32'(4 * 1016), 3'd7, 0);

      // Single read with latency check.
      wd[0] = 32'hDEADBEEF; wm[0] = 4'hF;
      do_write(BASE + 32'd20, 3'd0, 0);
      do_read(BASE + 32'd20, 3'd0, 0, 1'b1);
      chk("word5_model", model[5], 32'hDEADBEEF);

      // Burst read under 1,0,0 backpressure.
      for (int i = 0; i < 8; i++) begin wd[i] = 32'h100 + 32'(i); wm[i] = 4'hF; end
      do_write(BASE, 3'd7, 0);
      do_read(BASE, 3'd7, 1, 1'b1);

      // Masked write burst and read-back.
      wd[0] = 32'hAABBCCDD; wm[0] = 4'b0101;
      wd[1] = 32'h11223344; wm[1] = 4'b1111;
      do_write(BASE + 32'd8, 3'd1, 0);
      do_read(BASE + 32'd8, 3'd1, 0, 1'b0);

      // Bursts crossing the top of the window.
      do_read(BASE + 32'(4 * 1022), 3'd3, 0, 1'b0);
      wd[0] = 32'hCAFEF00D; wm[0] = 4'hF;
      wd[1] = 32'h0BADBEEF; wm[1] = 4'hF;
      do_write(BASE + 32'(4 * 1023), 3'd1, 0);
      do_read(BASE + 32'(4 * 1016), 3'd7, 0, 1'b0);

      // Misaligned and below-window addresses.
      do_read(BASE + 32'd2, 3'd0, 0, 1'b0);
      do_read(BASE - 32'd8, 3'd3, 0, 1'b0);

      // w_valid while idle is not consumed and writes nothing.
      for (int i = 0; i < 3; i++) begin
         wr_m.w_valid = 1'b1; wr_m.wdata = 32'hFFFF_FFFF; wr_m.wmask = 4'hF;
         @(negedge clk);
         chk("idle_w_ready", 32'(wr_s.w_ready), 32'd0);
         slot();
      end
      wr_m.w_valid = 1'b0;
      do_read(BASE, 3'd7, 0, 1'b0);

      // Randomized bursts against the reference model.
      for (int op = 0; op < 24; op++) begin
         r   = int'($urandom_range(0, 3));
         len = 3'($urandom_range(0, 7));
         case (r)
            0:       a = BASE + 32'(4 * $urandom_range(0, 16));
            1:       a = BASE + 32'(4 * (1016 + $urandom_range(0, 7)));
            2:       a = BASE + 32'(4 * $urandom_range(0, 16)) + 32'($urandom_range(1, 3));
            default: a = BASE - 32'(4 * $urandom_range(1, 3));
         endcase
         if ($urandom_range(0, 1) == 1) begin
            fill_random(1'b0);
            do_write(a, len, int'($urandom_range(0, 1)));
         end else begin
            do_read(a, len, int'($urandom_range(0, 2)), 1'b0);
         end
      end

      // Reset during beat 3 of an 8-beat write.
      send_cmd(BASE + 32'd64, 1'b0, 3'd7, t);
      for (int k = 0; k < 3; k++) begin
         wr_m.w_valid = 1'b1; wr_m.wdata = 32'h5A00_0000 + 32'(k); wr_m.wmask = 4'hF;
         @(negedge clk);
         chk("rst_burst_w_ready", 32'(wr_s.w_ready), 32'd1);
         model_write(BASE + 32'(64 + 4 * k), wr_m.wdata, 4'hF);
         slot();
      end
      wr_m.w_valid = 1'b1; wr_m.wdata = 32'h5A00_0003; wr_m.wmask = 4'hF;
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("mid_burst_reset");
      slot();
      wr_m.w_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_cmd_ready", 32'(cmd_s.cmd_ready), 32'd1);
      slot();
      do_read(BASE + 32'd64, 3'd7, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
